// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM-stage memory-access engine: access sizes,
// byte-lane mask width and the request FSM state encoding.
package mem_access_unit_pkg;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
   localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

   localparam int MEM_SEL_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DONE  = 2'd2,
      ST_DRAIN = 2'd3
   } mau_state_t;

endpackage

// File: rtl/mem_access_unit_align.sv
// Combinational byte-lane mask, store-data replication and misalignment
// detection for one load/store.
module mem_align
   import mem_access_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [1:0]            mem_size,
   input  logic [1:0]            addr_lo,
   input  logic [DATA_WIDTH-1:0] store_data,
   output logic [MEM_SEL_W-1:0]  lane_sel,
   output logic [DATA_WIDTH-1:0] lane_data,
   output logic                  misaligned
);

   always_comb begin
      lane_sel   = 4'b1111;
      lane_data  = store_data;
      misaligned = 1'b0;
      case (mem_size)
         MEM_SIZE_BYTE: begin
            lane_sel  = 4'b0001 << addr_lo;
            lane_data = {4{store_data[7:0]}};
         end
         MEM_SIZE_HALF: begin
            lane_sel   = 4'b0011 << {addr_lo[1], 1'b0};
            lane_data  = {2{store_data[15:0]}};
            misaligned = addr_lo[0];
         end
         MEM_SIZE_WORD: misaligned = |addr_lo;
         // size code 3 behaves as a word access
         default:       misaligned = |addr_lo;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage memory-access engine: issues byte-lane RAM requests, stalls the
// pipeline until the RAM answers, and hands the raw read word to MEM/WB.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  stall_current_stage,
   input  logic                  mem_read_flag_in,
   input  logic                  mem_write_flag_in,
   input  logic [1:0]            mem_size_in,
   input  logic [ADDR_WIDTH-1:0] address_in,
   input  logic [DATA_WIDTH-1:0] store_data_in,
   input  logic                  ram_ready,
   input  logic [DATA_WIDTH-1:0] ram_read_data,
   output logic                  ram_en,
   output logic [3:0]            ram_write_en,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_write_data,
   output logic [DATA_WIDTH-1:0] ram_read_data_out,
   output logic [3:0]            mem_sel_out,
   output logic                  stall_request,
   output logic                  addr_error_load,
   output logic                  addr_error_store
);

   logic [MEM_SEL_W-1:0]  lane_sel;
   logic [DATA_WIDTH-1:0] lane_data;
   logic                  misaligned;

   mem_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .mem_size   (mem_size_in),
      .addr_lo    (address_in[1:0]),
      .store_data (store_data_in),
      .lane_sel   (lane_sel),
      .lane_data  (lane_data),
      .misaligned (misaligned)
   );

   mau_state_t            state;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [3:0]            req_wen;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [3:0]            req_sel;
   logic [DATA_WIDTH-1:0] cap_data;

   logic in_idle;
   logic issue;

   assign in_idle = (state == ST_IDLE);
   assign issue   = in_idle && (mem_read_flag_in || mem_write_flag_in) && !misaligned && !flush;

   assign addr_error_load  = in_idle && mem_read_flag_in  && misaligned && !flush;
   assign addr_error_store = in_idle && mem_write_flag_in && misaligned && !flush;

   always_comb begin
      ram_en            = 1'b0;
      ram_write_en      = 4'b0;
      ram_addr          = '0;
      ram_write_data    = '0;
      ram_read_data_out = '0;
      mem_sel_out       = 4'b0;
      stall_request     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (issue) begin
               ram_en         = 1'b1;
               ram_addr       = {address_in[ADDR_WIDTH-1:2], 2'b00};
               ram_write_en   = mem_write_flag_in ? lane_sel : 4'b0;
               ram_write_data = mem_write_flag_in ? lane_data : '0;
               mem_sel_out    = lane_sel;
               stall_request  = !ram_ready;
               if (ram_ready) ram_read_data_out = ram_read_data;
            end
         end
         // WAIT and DRAIN replay the registered request so the RAM sees stable fields
         ST_WAIT: begin
            ram_en         = 1'b1;
            ram_addr       = req_addr;
            ram_write_en   = req_wen;
            ram_write_data = req_wdata;
            mem_sel_out    = req_sel;
            stall_request  = !ram_ready;
            if (ram_ready && !flush) ram_read_data_out = ram_read_data;
         end
         ST_DONE: begin
            mem_sel_out = req_sel;
            if (!flush) ram_read_data_out = cap_data;
         end
         ST_DRAIN: begin
            ram_en         = 1'b1;
            ram_addr       = req_addr;
            ram_write_en   = req_wen;
            ram_write_data = req_wdata;
            stall_request  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         req_addr  <= '0;
         req_wen   <= 4'b0;
         req_wdata <= '0;
         req_sel   <= 4'b0;
         cap_data  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (issue) begin
                  req_addr  <= {address_in[ADDR_WIDTH-1:2], 2'b00};
                  req_wen   <= mem_write_flag_in ? lane_sel : 4'b0;
                  req_wdata <= mem_write_flag_in ? lane_data : '0;
                  req_sel   <= lane_sel;
                  if (!ram_ready) begin
                     state <= ST_WAIT;
                  end else if (stall_current_stage) begin
                     state    <= ST_DONE;
                     cap_data <= ram_read_data;
                  end
               end
            end
            ST_WAIT: begin
               if (ram_ready) begin
                  if (!flush && stall_current_stage) begin
                     state    <= ST_DONE;
                     cap_data <= ram_read_data;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else if (flush) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DONE: begin
               if (flush) begin
                  state    <= ST_IDLE;
                  cap_data <= '0;
               end else if (!stall_current_stage) begin
                  state <= ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (ram_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level reference model.
module tb_mem_access_unit;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          stall_current_stage;
   logic          mem_read_flag_in;
   logic          mem_write_flag_in;
   logic [1:0]    mem_size_in;
   logic [AW-1:0] address_in;
   logic [DW-1:0] store_data_in;
   logic          ram_ready;
   logic [DW-1:0] ram_read_data;
   logic          ram_en;
   logic [3:0]    ram_write_en;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_write_data;
   logic [DW-1:0] ram_read_data_out;
   logic [3:0]    mem_sel_out;
   logic          stall_request;
   logic          addr_error_load;
   logic          addr_error_store;

   mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .flush               (flush),
      .stall_current_stage (stall_current_stage),
      .mem_read_flag_in    (mem_read_flag_in),
      .mem_write_flag_in   (mem_write_flag_in),
      .mem_size_in         (mem_size_in),
      .address_in          (address_in),
      .store_data_in       (store_data_in),
      .ram_ready           (ram_ready),
      .ram_read_data       (ram_read_data),
      .ram_en              (ram_en),
      .ram_write_en        (ram_write_en),
      .ram_addr            (ram_addr),
      .ram_write_data      (ram_write_data),
      .ram_read_data_out   (ram_read_data_out),
      .mem_sel_out         (mem_sel_out),
      .stall_request       (stall_request),
      .addr_error_load     (addr_error_load),
      .addr_error_store    (addr_error_store)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // stimulus for the next cycle
   logic        t_rd, t_wr, t_fl, t_scs, t_rs;
   logic [1:0]  t_sz;
   logic [31:0] t_a, t_d;

   // RAM responder
   bit          r_busy;
   int          r_lat;
   int          force_lat = -1;
   bit          force_rd_en = 1'b0;
   logic [31:0] force_rd;

   // reference model: one outstanding request, optionally killed, or a held result
   bit          m_pend, m_killed, m_hold;
   logic [31:0] m_addr, m_wdata, m_hdata;
   logic [3:0]  m_wen, m_sel, m_hsel;

   // expected and sampled outputs
   logic        e_en, e_stall, e_el, e_es;
   logic [3:0]  e_wen, e_sel;
   logic [31:0] e_addr, e_wdata, e_rdo;
   logic        s_en, s_stall, s_el, s_es;
   logic [3:0]  s_wen, s_sel;
   logic [31:0] s_addr, s_wdata, s_rdo;

   function automatic int size_bytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit is_misaligned(input logic [1:0] sz, input logic [31:0] a);
      return (int'(a[1:0]) % size_bytes(sz)) != 0;
   endfunction

   function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [31:0] a);
      int n, off;
      n   = size_bytes(sz);
      off = int'(a[1:0]);
      return 4'(((1 << n) - 1) << (off - off % n));
   endfunction

   function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
      int n;
      n = size_bytes(sz);
      if (n == 1) return 32'({24'd0, d[7:0]} * 32'h0101_0101);
      if (n == 2) return 32'({16'd0, d[15:0]} * 32'h0001_0001);
      return d;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_pend = 0; m_killed = 0; m_hold = 0;
      m_addr = 0; m_wdata = 0; m_hdata = 0; m_wen = 0; m_sel = 0; m_hsel = 0;
   endtask

   task automatic model_expect();
      e_en = 0; e_stall = 0; e_el = 0; e_es = 0;
      e_wen = 0; e_sel = 0; e_addr = 0; e_wdata = 0; e_rdo = 0;
      if (!t_rs) return;
      if (m_hold) begin
         e_sel = m_hsel;
         e_rdo = t_fl ? 32'd0 : m_hdata;
      end else if (m_pend) begin
         e_en    = 1;
         e_addr  = m_addr;
         e_wen   = m_wen;
         e_wdata = m_wdata;
         e_sel   = m_killed ? 4'd0 : m_sel;
         if (ram_ready && !m_killed && !t_fl) e_rdo = ram_read_data;
         e_stall = m_killed || !ram_ready;
      end else if ((t_rd || t_wr) && !t_fl) begin
         if (is_misaligned(t_sz, t_a)) begin
            e_el = t_rd;
            e_es = t_wr;
         end else begin
            e_en    = 1;
            e_addr  = t_a & ~32'd3;
            e_wen   = t_wr ? lanes(t_sz, t_a) : 4'd0;
            e_wdata = t_wr ? replicate(t_sz, t_d) : 32'd0;
            e_sel   = lanes(t_sz, t_a);
            e_rdo   = ram_ready ? ram_read_data : 32'd0;
            e_stall = !ram_ready;
         end
      end
   endtask

   task automatic model_update();
      if (!t_rs) begin
         model_clear();
      end else if (m_hold) begin
         if (t_fl || !t_scs) m_hold = 0;
      end else if (m_pend) begin
         if (ram_ready) begin
            m_pend = 0;
            if (!m_killed && !t_fl && t_scs) begin
               m_hold = 1; m_hdata = ram_read_data; m_hsel = m_sel;
            end
         end else if (t_fl) begin
            m_killed = 1;
         end
      end else if ((t_rd || t_wr) && !t_fl && !is_misaligned(t_sz, t_a)) begin
         if (ram_ready) begin
            if (t_scs) begin
               m_hold = 1; m_hdata = ram_read_data; m_hsel = lanes(t_sz, t_a);
            end
         end else begin
            m_pend   = 1;
            m_killed = 0;
            m_addr   = t_a & ~32'd3;
            m_wen    = t_wr ? lanes(t_sz, t_a) : 4'd0;
            m_wdata  = t_wr ? replicate(t_sz, t_d) : 32'd0;
            m_sel    = lanes(t_sz, t_a);
         end
      end
   endtask

   // one clock cycle, entered and left at the falling edge
   task automatic step();
      if (!t_rs) begin
         t_rd = 0; t_wr = 0; t_sz = 0; t_a = 0; t_d = 0; t_fl = 0; t_scs = 0;
      end
      rst                 = t_rs;
      mem_read_flag_in    = t_rd;
      mem_write_flag_in   = t_wr;
      mem_size_in         = t_sz;
      address_in          = t_a;
      store_data_in       = t_d;
      flush               = t_fl;
      stall_current_stage = t_scs;
      ram_ready           = 1'b0;
      ram_read_data       = '0;
      if (!t_rs) begin
         model_clear();
         r_busy = 0;
      end
      #1;
      if (ram_en && !r_busy) begin
         r_busy = 1;
         r_lat  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
      end
      ram_ready     = r_busy && (r_lat == 0);
      ram_read_data = force_rd_en ? force_rd : $urandom;
      #1;
      model_expect();
      s_en = ram_en; s_wen = ram_write_en; s_addr = ram_addr; s_wdata = ram_write_data;
      s_rdo = ram_read_data_out; s_sel = mem_sel_out; s_stall = stall_request;
      s_el = addr_error_load; s_es = addr_error_store;
      chk("ram_en",           32'(s_en),    32'(e_en));
      chk("ram_write_en",     32'(s_wen),   32'(e_wen));
      chk("ram_addr",         s_addr,       e_addr);
      chk("ram_write_data",   s_wdata,      e_wdata);
      chk("ram_read_data_out", s_rdo,       e_rdo);
      chk("mem_sel_out",      32'(s_sel),   32'(e_sel));
      chk("stall_request",    32'(s_stall), 32'(e_stall));
      chk("addr_error_load",  32'(s_el),    32'(e_el));
      chk("addr_error_store", 32'(s_es),    32'(e_es));
      @(posedge clk);
      model_update();
      if (r_busy) begin
         if (ram_ready) r_busy = 0;
         else r_lat--;
      end
      @(negedge clk);
   endtask

   task automatic set_ins(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
      t_rd = rd; t_wr = wr; t_sz = sz; t_a = a; t_d = d;
      t_fl = 0; t_scs = 0; t_rs = 1;
   endtask

   initial begin
      int  stalls;
      bit  need_new;
      int  kind;
      model_clear();
      r_busy = 0; r_lat = 0;
      set_ins(0, 0, 0, 0, 0);
      @(negedge clk);

      // reset state
      t_rs = 0;
      step();
      chk("rst_ram_en", 32'(s_en), 32'd0);
      chk("rst_stall",  32'(s_stall), 32'd0);
      step();
      chk("rst_rdo",    s_rdo, 32'd0);

      // store byte, zero-wait RAM
      set_ins(0, 1, 2'd0, 32'h1003, 32'h0000_00AB);
      force_lat = 0;
      step();
      chk("sb_wen",   32'(s_wen), 32'h8);
      chk("sb_wdata", s_wdata, 32'hABAB_ABAB);
      chk("sb_addr",  s_addr,  32'h1000);
      chk("sb_stall", 32'(s_stall), 32'd0);
      set_ins(0, 0, 0, 0, 0);
      step();

      // load word, 3-cycle RAM
      set_ins(1, 0, 2'd2, 32'h2000, 0);
      force_lat = 3; force_rd_en = 1; force_rd = 32'hDEAD_BEEF;
      stalls = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         stalls += int'(s_stall);
      end
      chk("lw_stall_cycles", 32'(stalls), 32'd3);
      chk("lw_rdo", s_rdo, 32'hDEAD_BEEF);
      chk("lw_sel", 32'(s_sel), 32'hF);
      set_ins(0, 0, 0, 0, 0);
      step();

      // misaligned load half
      set_ins(1, 0, 2'd1, 32'h2001, 0);
      step();
      chk("lh_mis_err",   32'(s_el), 32'd1);
      chk("lh_mis_en",    32'(s_en), 32'd0);
      chk("lh_mis_stall", 32'(s_stall), 32'd0);

      // completion while MEM is held -> DONE, captured data held
      set_ins(1, 0, 2'd2, 32'h2004, 0);
      t_scs = 1; force_lat = 1; force_rd = 32'h1234_5678;
      step();
      step();
      chk("done_cmpl_rdo", s_rdo, 32'h1234_5678);
      force_rd = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("done_no_reissue", 32'(s_en), 32'd0);
         chk("done_rdo_held",   s_rdo, 32'h1234_5678);
      end
      t_scs = 0;
      step();
      set_ins(0, 0, 0, 0, 0);
      step();

      // flush in WAIT -> DRAIN; store arriving during DRAIN waits
      set_ins(1, 0, 2'd2, 32'h3000, 0);
      force_lat = 3; force_rd = 32'hCAFE_F00D;
      step();
      t_fl = 1;
      step();
      set_ins(0, 1, 2'd2, 32'h4000, 32'h5555_AAAA);
      step();
      chk("drain_en",    32'(s_en), 32'd1);
      chk("drain_addr",  s_addr, 32'h3000);
      chk("drain_stall", 32'(s_stall), 32'd1);
      step();
      chk("drain_rdy_rdo",   s_rdo, 32'd0);
      chk("drain_rdy_stall", 32'(s_stall), 32'd1);
      force_lat = 0;
      step();
      chk("post_drain_addr", s_addr, 32'h4000);
      chk("post_drain_wen",  32'(s_wen), 32'hF);
      set_ins(0, 0, 0, 0, 0);
      step();

      // reset mid-WAIT
      set_ins(1, 0, 2'd2, 32'h5000, 0);
      force_lat = 3;
      step();
      step();
      t_rs = 0;
      step();
      chk("rst_wait_en",    32'(s_en), 32'd0);
      chk("rst_wait_stall", 32'(s_stall), 32'd0);
      chk("rst_wait_rdo",   s_rdo, 32'd0);
      set_ins(0, 0, 0, 0, 0);
      step();
      chk("rst_after_en", 32'(s_en), 32'd0);

      // randomized traffic
      force_lat = -1; force_rd_en = 0;
      need_new = 1;
      for (int i = 0; i < 3000; i++) begin
         if (need_new) begin
            kind = int'($urandom_range(0, 2));
            t_rd = (kind == 1);
            t_wr = (kind == 2);
            t_sz = 2'($urandom_range(0, 3));
            t_a  = $urandom;
            if ($urandom_range(0, 1) == 0) t_a[1:0] = 2'b00;
            t_d  = $urandom;
         end
         t_scs = ($urandom_range(0, 3) == 0);
         t_fl  = ($urandom_range(0, 11) == 0);
         t_rs  = !($urandom_range(0, 249) == 0);
         step();
         need_new = t_fl || !t_rs || !(e_stall || t_scs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
